// File: rtl/xif_mul_seq.sv
// Custom-opcode MUL/MULHU unit: issue FIFO feeding a 32-step shift-add multiplier.
// Result 34 cycles after enqueue into an idle unit; issue_ready_o drops when FIFO full; no result stall.
module xif_mul_seq #(
  parameter logic [6:0] OPCODE = 7'h5B,
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid_i,
  output logic        issue_ready_o,
  output logic        issue_accept_o,
  input  logic [31:0] issue_instr_i,
  input  logic [31:0] issue_op0_i,
  input  logic [31:0] issue_op1_i,
  input  logic [3:0]  issue_id_i,
  output logic        result_valid_o,
  output logic [3:0]  result_id_o,
  output logic [4:0]  result_rd_o,
  output logic [31:0] result_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] op0;
    logic [31:0] op1;
    logic [3:0]  id;
    logic [4:0]  rd;
    logic        hi;
  } entry_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  entry_t        fifo_q [DEPTH];
  entry_t        wr_entry;
  entry_t        head;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   cnt_q;
  logic          push, pop;

  state_t        state_q, state_d;
  logic [63:0]   acc_q, acc_d, acc_step;
  logic [31:0]   mcand_q, mcand_d;
  logic [5:0]    step_q, step_d;
  logic [3:0]    cur_id_q, cur_id_d;
  logic [4:0]    cur_rd_q, cur_rd_d;
  logic          cur_hi_q, cur_hi_d;
  logic [32:0]   sum;

  logic          res_vld_q, res_vld_d;
  logic [3:0]    res_id_q, res_id_d;
  logic [4:0]    res_rd_q, res_rd_d;
  logic [31:0]   res_q, res_d;

  logic [2:0]    funct3;
  logic          unused_instr;

  assign funct3         = issue_instr_i[14:12];
  assign issue_accept_o = (issue_instr_i[6:0] == OPCODE) && (issue_instr_i[31:25] == 7'h01) &&
                          ((funct3 == 3'b000) || (funct3 == 3'b011));
  assign unused_instr   = ^issue_instr_i[24:15];
  assign issue_ready_o  = (cnt_q < FULL_CNT);
  assign push           = issue_valid_i & issue_ready_o & issue_accept_o;

  assign wr_entry = '{op0: issue_op0_i, op1: issue_op1_i, id: issue_id_i,
                      rd: issue_instr_i[11:7], hi: (funct3 == 3'b011)};
  assign head     = fifo_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= wr_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Add multiplicand into the upper 33 bits, then shift the whole accumulator right.
  assign sum      = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
  assign acc_step = {sum, acc_q[31:1]};

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    step_d    = step_q;
    cur_id_d  = cur_id_q;
    cur_rd_d  = cur_rd_q;
    cur_hi_d  = cur_hi_q;
    res_vld_d = 1'b0;
    res_id_d  = res_id_q;
    res_rd_d  = res_rd_q;
    res_d     = res_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (cnt_q != '0) begin
          pop      = 1'b1;
          state_d  = RUN;
          acc_d    = {32'd0, head.op1};
          mcand_d  = head.op0;
          step_d   = 6'd0;
          cur_id_d = head.id;
          cur_rd_d = head.rd;
          cur_hi_d = head.hi;
        end
      end
      RUN: begin
        acc_d  = acc_step;
        step_d = step_q + 6'd1;
        // Final step: capture the finished product so results are valid throughout DONE.
        if (step_q == 6'd31) begin
          state_d   = DONE;
          res_vld_d = 1'b1;
          res_id_d  = cur_id_q;
          res_rd_d  = cur_rd_q;
          res_d     = cur_hi_q ? acc_step[63:32] : acc_step[31:0];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      step_q    <= '0;
      cur_id_q  <= '0;
      cur_rd_q  <= '0;
      cur_hi_q  <= 1'b0;
      res_vld_q <= 1'b0;
      res_id_q  <= '0;
      res_rd_q  <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      step_q    <= step_d;
      cur_id_q  <= cur_id_d;
      cur_rd_q  <= cur_rd_d;
      cur_hi_q  <= cur_hi_d;
      res_vld_q <= res_vld_d;
      res_id_q  <= res_id_d;
      res_rd_q  <= res_rd_d;
      res_q     <= res_d;
    end
  end

  assign result_valid_o = res_vld_q;
  assign result_id_o    = res_id_q;
  assign result_rd_o    = res_rd_q;
  assign result_o       = res_q;
endmodule

// File: tb/tb_xif_mul_seq.sv
// Bench for xif_mul_seq: scoreboard of expected id/rd/data/cycle, checked as results strobe out.
module tb_xif_mul_seq;
  localparam logic [6:0] OPC = 7'h5B;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid_i = 1'b0;
  logic        issue_ready_o, issue_accept_o;
  logic [31:0] issue_instr_i = '0, issue_op0_i = '0, issue_op1_i = '0;
  logic [3:0]  issue_id_i = '0;
  logic        result_valid_o;
  logic [3:0]  result_id_o;
  logic [4:0]  result_rd_o;
  logic [31:0] result_o;

  xif_mul_seq #(.OPCODE(OPC), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o), .issue_accept_o(issue_accept_o),
    .issue_instr_i(issue_instr_i), .issue_op0_i(issue_op0_i), .issue_op1_i(issue_op1_i),
    .issue_id_i(issue_id_i),
    .result_valid_o(result_valid_o), .result_id_o(result_id_o), .result_rd_o(result_rd_o),
    .result_o(result_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  id;
    logic [4:0]  rd;
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_err = 0, cyc = 0, res_cnt = 0, last_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && result_valid_o) begin
      res_cnt++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_result: got id=%0d rd=%0d data=%h at cycle %0d, required no result",
                 result_id_o, result_rd_o, result_o, cyc);
      end else begin
        e = sb.pop_front();
        if (result_id_o !== e.id || result_rd_o !== e.rd || result_o !== e.res || cyc != e.cyc) begin
          n_err++;
          $display("FAIL result: got id=%0d rd=%0d data=%h cycle=%0d, required id=%0d rd=%0d data=%h cycle=%0d",
                   result_id_o, result_rd_o, result_o, cyc, e.id, e.rd, e.res, e.cyc);
        end
      end
    end
  end

  function automatic logic [31:0] enc(input logic [2:0] f3, input logic [6:0] opc, input logic [4:0] rd);
    return {7'h01, 5'd2, 5'd1, f3, rd, opc};
  endfunction

  // Timing model: the engine takes a new entry the cycle after enqueue or after the previous DONE.
  task automatic expect_res(input logic [3:0] id, input logic [4:0] rd, input logic [31:0] res, input int acc);
    int pop_cyc;
    pop_cyc = (acc + 1 > last_done + 1) ? acc + 1 : last_done + 1;
    last_done = pop_cyc + 33;
    sb.push_back('{id, rd, res, last_done});
  endtask

  // Called #1 after a rising edge; returns the cycle in which the enqueue handshake happened.
  task automatic do_issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] id, output int acc);
    acc = -1;
    issue_valid_i = 1'b1; issue_instr_i = ins; issue_op0_i = a; issue_op1_i = b; issue_id_i = id;
    for (int i = 0; i < 200; i++) begin
      if (issue_ready_o) begin
        acc = cyc;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    issue_valid_i = 1'b0;
    if (acc < 0) begin
      n_cmp++; n_err++;
      $display("FAIL issue_timeout: id=%0d never taken, required ready within 200 cycles", id);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (result_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b, required 0", result_valid_o); end
    n_cmp++; if (result_id_o !== 4'd0)    begin n_err++; $display("FAIL rst_id: got %0d, required 0", result_id_o); end
    n_cmp++; if (result_rd_o !== 5'd0)    begin n_err++; $display("FAIL rst_rd: got %0d, required 0", result_rd_o); end
    n_cmp++; if (result_o !== 32'd0)      begin n_err++; $display("FAIL rst_data: got %h, required 0", result_o); end
    reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (issue_ready_o !== 1'b1)  begin n_err++; $display("FAIL rst_ready: got %b, required 1", issue_ready_o); end
  endtask

  task automatic test_mul_basic;
    int c;
    issue_instr_i = enc(3'b000, OPC, 5'd10);
    #1;
    n_cmp++; if (issue_accept_o !== 1'b1) begin n_err++; $display("FAIL mul_accept: got %b, required 1", issue_accept_o); end
    do_issue(enc(3'b000, OPC, 5'd10), 32'd3, 32'd5, 4'd2, c);
    expect_res(4'd2, 5'd10, 32'd15, c);
    for (int i = 0; i < 60 && sb.size() != 0; i++) begin @(posedge clk); #1; end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL mul_basic_drain: %0d results outstanding, required 0", sb.size()); end
    @(posedge clk); #1;
    n_cmp++; if (result_o !== 32'd15 || result_valid_o !== 1'b0) begin
      n_err++; $display("FAIL mul_hold: got data=%h valid=%b, required data=0000000f valid=0", result_o, result_valid_o);
    end
  endtask

  task automatic test_mulhu;
    int c;
    do_issue(enc(3'b011, OPC, 5'd5), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3, c);
    expect_res(4'd3, 5'd5, 32'hFFFF_FFFE, c);
    do_issue(enc(3'b000, OPC, 5'd6), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd4, c);
    expect_res(4'd4, 5'd6, 32'h0000_0001, c);
    for (int i = 0; i < 120 && sb.size() != 0; i++) begin @(posedge clk); #1; end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL mulhu_drain: %0d results outstanding, required 0", sb.size()); end
  endtask

  task automatic test_reject;
    int rc;
    logic [31:0] bad [2];
    bad[0] = enc(3'b000, 7'h0B, 5'd7);
    bad[1] = enc(3'b001, OPC, 5'd7);
    rc = res_cnt;
    for (int k = 0; k < 2; k++) begin
      issue_valid_i = 1'b1; issue_instr_i = bad[k]; issue_op0_i = 32'd9; issue_op1_i = 32'd9; issue_id_i = 4'd7;
      #1;
      n_cmp++; if (issue_accept_o !== 1'b0) begin n_err++; $display("FAIL reject_accept%0d: got %b, required 0", k, issue_accept_o); end
      repeat (3) @(posedge clk);
      #1;
    end
    issue_valid_i = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    n_cmp++; if (res_cnt != rc) begin n_err++; $display("FAIL reject_noresult: got %0d results, required 0", res_cnt - rc); end
    n_cmp++; if (issue_ready_o !== 1'b1) begin n_err++; $display("FAIL reject_ready: got %b, required 1", issue_ready_o); end
  endtask

  task automatic test_random;
    int c;
    logic [31:0] a, b;
    logic [63:0] p;
    logic        hi;
    for (int k = 0; k < 6; k++) begin
      a = $urandom; b = $urandom; hi = 1'($urandom_range(0, 1));
      p = 64'(a) * 64'(b);
      do_issue(enc(hi ? 3'b011 : 3'b000, OPC, 5'(k + 12)), a, b, 4'(k + 5), c);
      expect_res(4'(k + 5), 5'(k + 12), hi ? p[63:32] : p[31:0], c);
    end
    for (int i = 0; i < 300 && sb.size() != 0; i++) begin @(posedge clk); #1; end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL random_drain: %0d results outstanding, required 0", sb.size()); end
  endtask

  task automatic test_back_to_back;
    int c0, c;
    do_issue(enc(3'b000, OPC, 5'd20), 32'd100, 32'd200, 4'd0, c0);
    expect_res(4'd0, 5'd20, 32'd20000, c0);
    for (int k = 1; k <= 4; k++) begin
      do_issue(enc(3'b000, OPC, 5'(20 + k)), 32'(k), 32'd1000, 4'(k), c);
      expect_res(4'(k), 5'(20 + k), 32'(k * 1000), c);
    end
    n_cmp++; if (c != c0 + 4) begin n_err++; $display("FAIL b2b_fourth: taken cycle %0d, required %0d", c, c0 + 4); end
    n_cmp++; if (issue_ready_o !== 1'b0) begin n_err++; $display("FAIL b2b_full_ready: got %b, required 0", issue_ready_o); end
    do_issue(enc(3'b011, OPC, 5'd25), 32'hDEAD_BEEF, 32'h1234_5678, 4'd5, c);
    expect_res(4'd5, 5'd25, 32'h0FD5_BDEE, c);
    n_cmp++; if (c != c0 + 36) begin n_err++; $display("FAIL b2b_fifth: taken cycle %0d, required %0d", c, c0 + 36); end
    for (int i = 0; i < 300 && sb.size() != 0; i++) begin @(posedge clk); #1; end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL b2b_drain: %0d results outstanding, required 0", sb.size()); end
  endtask

  task automatic test_reset_mid_run;
    int c, rc;
    do_issue(enc(3'b000, OPC, 5'd1), 32'd11, 32'd13, 4'd8, c);
    do_issue(enc(3'b000, OPC, 5'd2), 32'd17, 32'd19, 4'd9, rc);
    do_issue(enc(3'b000, OPC, 5'd3), 32'd23, 32'd29, 4'd10, rc);
    while (cyc < c + 12) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    n_cmp++; if (result_o !== 32'd0 || result_id_o !== 4'd0 || result_rd_o !== 5'd0 || result_valid_o !== 1'b0) begin
      n_err++; $display("FAIL midrun_outputs: got valid=%b id=%0d rd=%0d data=%h, required all 0",
                        result_valid_o, result_id_o, result_rd_o, result_o);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    last_done = 0;
    rc = res_cnt;
    @(posedge clk); #1;
    n_cmp++; if (issue_ready_o !== 1'b1) begin n_err++; $display("FAIL midrun_ready: got %b, required 1", issue_ready_o); end
    repeat (100) @(posedge clk);
    #1;
    n_cmp++; if (res_cnt != rc) begin n_err++; $display("FAIL midrun_noresult: got %0d results, required 0", res_cnt - rc); end
    do_issue(enc(3'b000, OPC, 5'd4), 32'd7, 32'd6, 4'd11, c);
    expect_res(4'd11, 5'd4, 32'd42, c);
    for (int i = 0; i < 60 && sb.size() != 0; i++) begin @(posedge clk); #1; end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL midrun_drain: %0d results outstanding, required 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_mulhu();
    test_reject();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
